control_unit: RTL and testbench

- Multi-cycle control sequencer that drives every control and enable input of the mini-CPU data path.
- Fetches and decodes the IR opcode, then steps through fixed T-state sequences for each instruction class.
- Samples branchCompare from CON_FF to resolve branches.
- Sits beside data_path at the top level and replaces bench-driven control signals.

---
 rtl/control_unit_pkg.sv | 69 ++++++
 rtl/control_unit_mem_wait_ctr.sv | 25 ++
 rtl/control_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_control_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared definitions for the mini-CPU control sequencer: opcodes, FSM state
// encoding, instruction classes and the packed control word.
package cpu_defs;

  typedef logic [4:0] opcode_t;

  localparam opcode_t OP_LD   = 5'b00000;
  localparam opcode_t OP_LDI  = 5'b00001;
  localparam opcode_t OP_ST   = 5'b00010;
  localparam opcode_t OP_ADD  = 5'b00011;
  localparam opcode_t OP_ROL  = 5'b01011;
  localparam opcode_t OP_ADDI = 5'b01100;
  localparam opcode_t OP_ORI  = 5'b01110;
  localparam opcode_t OP_MUL  = 5'b01111;
  localparam opcode_t OP_DIV  = 5'b10000;
  localparam opcode_t OP_NEG  = 5'b10001;
  localparam opcode_t OP_NOT  = 5'b10010;
  localparam opcode_t OP_BR   = 5'b10011;
  localparam opcode_t OP_JR   = 5'b10100;
  localparam opcode_t OP_IN   = 5'b10110;
  localparam opcode_t OP_OUT  = 5'b10111;
  localparam opcode_t OP_MFHI = 5'b11000;
  localparam opcode_t OP_MFLO = 5'b11001;
  localparam opcode_t OP_NOP  = 5'b11010;
  localparam opcode_t OP_HALT = 5'b11011;

  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_T0    = 4'd1;
  localparam logic [3:0] S_T1    = 4'd2;
  localparam logic [3:0] S_T2    = 4'd3;
  localparam logic [3:0] S_T3    = 4'd4;
  localparam logic [3:0] S_T4    = 4'd5;
  localparam logic [3:0] S_T5    = 4'd6;
  localparam logic [3:0] S_T6    = 4'd7;
  localparam logic [3:0] S_T7    = 4'd8;
  localparam logic [3:0] S_HALT  = 4'd9;
  localparam logic [3:0] S_ILL   = 4'd10;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_IMM, CLS_MEM, CLS_MULDIV, CLS_UNARY, CLS_BR, CLS_1CYC, CLS_ILL
  } cls_e;

  typedef struct packed {
    logic ir_load, read, write;
    logic gra, grb, grc, rin, rout, ba_out;
    logic hi_out, lo_out, zhigh_out, zlow_out, pc_out, mdr_out, inport_out, ram_out, c_out;
    logic hi_in, lo_in, zhigh_in, zlow_in, pc_in, mdr_in, outport_in, y_in, mar_in, inc_pc;
    logic run, illegal_op;
  } ctrl_t;

  // nop and halt are grouped with the single-cycle class; the sequencer
  // intercepts them by opcode before T3.
  function automatic cls_e classify(input opcode_t op);
    cls_e cls;
    case (op) inside
      OP_LD, OP_LDI, OP_ST:                    cls = CLS_MEM;
      [OP_ADD:OP_ROL]:                         cls = CLS_ALU;
      [OP_ADDI:OP_ORI]:                        cls = CLS_IMM;
      OP_MUL, OP_DIV:                          cls = CLS_MULDIV;
      OP_NEG, OP_NOT:                          cls = CLS_UNARY;
      OP_BR:                                   cls = CLS_BR;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO,
      OP_NOP, OP_HALT:                         cls = CLS_1CYC;
      default:                                 cls = CLS_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/control_unit_mem_wait_ctr.sv
// Loadable 3-bit down-counter that stretches memory reads; done flags zero.
module mem_wait_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       dec,
  input  logic [2:0] value,
  output logic [2:0] count,
  output logic       done
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= 3'd0;
    else if (load)
      count <= value;
    else if (dec && count != 3'd0)
      count <= count - 3'd1;
  end

  assign done = (count == 3'd0);

endmodule

// File: rtl/control_unit.sv
// Multi-cycle Moore sequencer driving every control input of the mini-CPU
// data path; outputs decode only from registered state.
module control_unit
  import cpu_defs::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int OPC_W    = 5
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] irOut,
  input  logic        branchCompare,
  input  logic        stop,
  output logic        ir_load,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAOut,
  output logic        HIout,
  output logic        LOout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        PCout,
  output logic        MDRout,
  output logic        InPortout,
  output logic        RAMout,
  output logic        Cout,
  output logic        HIin,
  output logic        LOin,
  output logic        Zhighin,
  output logic        Zlowin,
  output logic        PCin,
  output logic        MDRin,
  output logic        OutPortin,
  output logic        Yin,
  output logic        MARin,
  output logic        IncPC,
  output logic        run,
  output logic        illegal_op
);

  localparam logic [2:0] WAIT_LD = 3'(MEM_WAIT);

  logic [3:0] state, nxt;
  opcode_t    opc_q, ir_opc;
  cls_e       cls_q, ir_cls;
  logic       br_flag;
  logic       ctr_load, ctr_dec, wait_done;
  logic [2:0] wait_count;
  logic       is_ld;
  logic       unused_ir;
  ctrl_t      c;

  assign ir_opc    = opcode_t'(irOut[31 -: OPC_W]);
  assign ir_cls    = classify(ir_opc);
  assign unused_ir = ^irOut[31-OPC_W:0];
  assign is_ld     = (cls_q == CLS_MEM) && (opc_q == OP_LD);

  assign ctr_load = (state == S_T0) || (state == S_T5 && is_ld);
  assign ctr_dec  = (state == S_T1) || (state == S_T6 && is_ld);

  mem_wait_ctr u_wait (
    .clk   (clock),
    .rst_n (clear),
    .load  (ctr_load),
    .dec   (ctr_dec),
    .value (WAIT_LD),
    .count (wait_count),
    .done  (wait_done)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_RESET: nxt = S_T0;
      S_T0:    nxt = S_T1;
      S_T1:    nxt = wait_done ? S_T2 : S_T1;
      S_T2: begin
        if (ir_opc == OP_NOP)        nxt = S_T0;
        else if (ir_opc == OP_HALT)  nxt = S_HALT;
        else if (ir_cls == CLS_ILL)  nxt = S_ILL;
        else                         nxt = S_T3;
      end
      S_T3:    nxt = (cls_q == CLS_1CYC) ? S_T0 : S_T4;
      S_T4:    nxt = (cls_q == CLS_UNARY) ? S_T0 : S_T5;
      S_T5: begin
        if (cls_q == CLS_ALU || cls_q == CLS_IMM)          nxt = S_T0;
        else if (cls_q == CLS_MEM && opc_q == OP_LDI)      nxt = S_T0;
        else                                               nxt = S_T6;
      end
      S_T6:    nxt = (is_ld) ? (wait_done ? S_T7 : S_T6) : S_T0;
      S_T7:    nxt = S_T0;
      S_ILL:   nxt = S_HALT;
      default: nxt = S_HALT;
    endcase
    // stop only takes effect between instructions
    if (nxt == S_T0 && stop)
      nxt = S_HALT;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= S_RESET;
      opc_q   <= OP_LD;
      cls_q   <= CLS_ILL;
      br_flag <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_T2) begin
        opc_q <= ir_opc;
        cls_q <= ir_cls;
      end
      if (state == S_T3 && cls_q == CLS_BR)
        br_flag <= branchCompare;
    end
  end

  always_comb begin
    c = '0;  // NOTE: defaulting every field first keeps this block latch-free
    case (state)
      S_T0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.zlow_in = 1'b1; end
      S_T1: begin
        c.zlow_out = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1;
        c.pc_in    = (wait_count == WAIT_LD);
      end
      S_T2: begin c.mdr_out = 1'b1; c.ir_load = 1'b1; end
      S_T3: begin
        case (cls_q)
          CLS_ALU, CLS_IMM: begin c.grb = 1'b1; c.rout = 1'b1; c.y_in = 1'b1; end
          CLS_MEM:          begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
          CLS_MULDIV:       begin c.gra = 1'b1; c.rout = 1'b1; c.y_in = 1'b1; end
          CLS_UNARY:        begin c.grb = 1'b1; c.rout = 1'b1; c.zlow_in = 1'b1; end
          CLS_BR:           begin c.gra = 1'b1; c.rout = 1'b1; end
          CLS_1CYC: begin
            case (opc_q)
              OP_JR:   begin c.gra = 1'b1; c.rout = 1'b1; c.pc_in = 1'b1; end
              OP_IN:   begin c.inport_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
              OP_OUT:  begin c.gra = 1'b1; c.rout = 1'b1; c.outport_in = 1'b1; end
              OP_MFHI: begin c.hi_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
              OP_MFLO: begin c.lo_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls_q)
          CLS_ALU:          begin c.grc = 1'b1; c.rout = 1'b1; c.zlow_in = 1'b1; end
          CLS_IMM, CLS_MEM: begin c.c_out = 1'b1; c.zlow_in = 1'b1; end
          CLS_MULDIV: begin
            c.grb = 1'b1; c.rout = 1'b1; c.zhigh_in = 1'b1; c.zlow_in = 1'b1;
          end
          CLS_UNARY:        begin c.zlow_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          CLS_BR:           begin c.pc_out = 1'b1; c.y_in = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls_q)
          CLS_ALU, CLS_IMM: begin c.zlow_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          CLS_MEM: begin
            c.zlow_out = 1'b1;
            if (opc_q == OP_LDI) begin c.gra = 1'b1; c.rin = 1'b1; end
            else                 c.mar_in = 1'b1;
          end
          CLS_MULDIV:       begin c.zlow_out = 1'b1; c.lo_in = 1'b1; end
          CLS_BR:           begin c.c_out = 1'b1; c.zlow_in = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls_q)
          CLS_MEM: begin
            if (opc_q == OP_LD) begin c.read = 1'b1; c.mdr_in = 1'b1; end
            else begin c.gra = 1'b1; c.rout = 1'b1; c.write = 1'b1; end
          end
          CLS_MULDIV: begin c.zhigh_out = 1'b1; c.hi_in = 1'b1; end
          CLS_BR:     begin c.zlow_out = br_flag; c.pc_in = br_flag; end
          default: ;
        endcase
      end
      S_T7:  begin c.mdr_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
      S_ILL: c.illegal_op = 1'b1;
      default: ;
    endcase
    c.run = (state != S_RESET) && (state != S_HALT);
  end

  assign ir_load    = c.ir_load;
  assign Read       = c.read;
  assign Write      = c.write;
  assign Gra        = c.gra;
  assign Grb        = c.grb;
  assign Grc        = c.grc;
  assign Rin        = c.rin;
  assign Rout       = c.rout;
  assign BAOut      = c.ba_out;
  assign HIout      = c.hi_out;
  assign LOout      = c.lo_out;
  assign Zhighout   = c.zhigh_out;
  assign Zlowout    = c.zlow_out;
  assign PCout      = c.pc_out;
  assign MDRout     = c.mdr_out;
  assign InPortout  = c.inport_out;
  assign RAMout     = c.ram_out;
  assign Cout       = c.c_out;
  assign HIin       = c.hi_in;
  assign LOin       = c.lo_in;
  assign Zhighin    = c.zhigh_in;
  assign Zlowin     = c.zlow_in;
  assign PCin       = c.pc_in;
  assign MDRin      = c.mdr_in;
  assign OutPortin  = c.outport_in;
  assign Yin        = c.y_in;
  assign MARin      = c.mar_in;
  assign IncPC      = c.inc_pc;
  assign run        = c.run;
  assign illegal_op = c.illegal_op;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: compares the full control word each cycle
// against hand-built masks for fetch, each instruction class, stop and reset.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] irOut = '0;
  logic        branchCompare = 1'b0;
  logic        stop = 1'b0;
  logic ir_load, Read, Write, Gra, Grb, Grc, Rin, Rout, BAOut;
  logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, RAMout, Cout;
  logic HIin, LOin, Zhighin, Zlowin, PCin, MDRin, OutPortin, Yin, MARin, IncPC;
  logic run, illegal_op;

  int n_checks = 0;
  int n_errors = 0;

  control_unit #(.MEM_WAIT(1), .OPC_W(5)) dut (
    .clock(clock), .clear(clear), .irOut(irOut), .branchCompare(branchCompare), .stop(stop),
    .ir_load(ir_load), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAOut(BAOut), .HIout(HIout), .LOout(LOout),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .PCout(PCout), .MDRout(MDRout),
    .InPortout(InPortout), .RAMout(RAMout), .Cout(Cout), .HIin(HIin), .LOin(LOin),
    .Zhighin(Zhighin), .Zlowin(Zlowin), .PCin(PCin), .MDRin(MDRin), .OutPortin(OutPortin),
    .Yin(Yin), .MARin(MARin), .IncPC(IncPC), .run(run), .illegal_op(illegal_op)
  );

  always #5 clock = ~clock;

  logic [29:0] outs;
  assign outs = {ir_load, Read, Write, Gra, Grb, Grc, Rin, Rout, BAOut,
                 HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, RAMout, Cout,
                 HIin, LOin, Zhighin, Zlowin, PCin, MDRin, OutPortin, Yin, MARin, IncPC,
                 run, illegal_op};

  localparam logic [29:0] M_IRL  = 30'h1 << 29, M_RD   = 30'h1 << 28, M_WR   = 30'h1 << 27;
  localparam logic [29:0] M_GRA  = 30'h1 << 26, M_GRB  = 30'h1 << 25, M_GRC  = 30'h1 << 24;
  localparam logic [29:0] M_RIN  = 30'h1 << 23, M_ROUT = 30'h1 << 22, M_BAO  = 30'h1 << 21;
  localparam logic [29:0] M_HIO  = 30'h1 << 20, M_LOO  = 30'h1 << 19, M_ZHO  = 30'h1 << 18;
  localparam logic [29:0] M_ZLO  = 30'h1 << 17, M_PCO  = 30'h1 << 16, M_MDRO = 30'h1 << 15;
  localparam logic [29:0] M_COUT = 30'h1 << 12, M_HII  = 30'h1 << 11, M_LOI  = 30'h1 << 10;
  localparam logic [29:0] M_ZHI  = 30'h1 << 9,  M_ZLI  = 30'h1 << 8,  M_PCI  = 30'h1 << 7;
  localparam logic [29:0] M_MDRI = 30'h1 << 6,  M_YIN  = 30'h1 << 4,  M_MARI = 30'h1 << 3;
  localparam logic [29:0] M_INC  = 30'h1 << 2,  M_RUN  = 30'h1 << 1,  M_ILL  = 30'h1;

  localparam logic [29:0] E_T0  = M_PCO | M_MARI | M_INC | M_ZLI | M_RUN;
  localparam logic [29:0] E_T1A = M_ZLO | M_PCI | M_RD | M_MDRI | M_RUN;
  localparam logic [29:0] E_T1B = M_ZLO | M_RD | M_MDRI | M_RUN;
  localparam logic [29:0] E_T2  = M_MDRO | M_IRL | M_RUN;
  localparam logic [29:0] E_AGU3 = M_GRB | M_BAO | M_YIN | M_RUN;
  localparam logic [29:0] E_AGU4 = M_COUT | M_ZLI | M_RUN;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // compare the current control word, then advance to 1 ns after the next edge
  task automatic cyc(input string tag, input logic [29:0] exp);
    check(tag, {2'b00, outs}, {2'b00, exp});
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [31:0] ir);
    irOut = ir;
    cyc({tag, "_t0"}, E_T0);
    cyc({tag, "_t1a"}, E_T1A);
    cyc({tag, "_t1b"}, E_T1B);
    cyc({tag, "_t2"}, E_T2);
  endtask

  task automatic do_reset();
    clear = 1'b0;
    #1;
    check("rst_async", {2'b00, outs}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check("rst_hold", {2'b00, outs}, 32'h0);
    end
    clear = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    do_reset();

    fetch("add", 32'h1A2B_8000);
    cyc("add_t3", M_GRB | M_ROUT | M_YIN | M_RUN);
    cyc("add_t4", M_GRC | M_ROUT | M_ZLI | M_RUN);
    cyc("add_t5", M_ZLO | M_GRA | M_RIN | M_RUN);

    fetch("ld", 32'h0000_0000);
    cyc("ld_t3", E_AGU3);
    cyc("ld_t4", E_AGU4);
    cyc("ld_t5", M_ZLO | M_MARI | M_RUN);
    cyc("ld_t6a", M_RD | M_MDRI | M_RUN);
    cyc("ld_t6b", M_RD | M_MDRI | M_RUN);
    cyc("ld_t7", M_MDRO | M_GRA | M_RIN | M_RUN);

    fetch("st", 32'h1000_0000);
    cyc("st_t3", E_AGU3);
    cyc("st_t4", E_AGU4);
    cyc("st_t5", M_ZLO | M_MARI | M_RUN);
    cyc("st_t6", M_GRA | M_ROUT | M_WR | M_RUN);

    fetch("addi", 32'h6000_0000);
    cyc("addi_t3", M_GRB | M_ROUT | M_YIN | M_RUN);
    cyc("addi_t4", E_AGU4);
    cyc("addi_t5", M_ZLO | M_GRA | M_RIN | M_RUN);

    branchCompare = 1'b1;
    fetch("brt", 32'h9800_0000);
    cyc("brt_t3", M_GRA | M_ROUT | M_RUN);
    branchCompare = 1'b0;
    cyc("brt_t4", M_PCO | M_YIN | M_RUN);
    cyc("brt_t5", M_COUT | M_ZLI | M_RUN);
    cyc("brt_t6", M_ZLO | M_PCI | M_RUN);

    fetch("brn", 32'h9800_0000);
    cyc("brn_t3", M_GRA | M_ROUT | M_RUN);
    branchCompare = 1'b1;
    cyc("brn_t4", M_PCO | M_YIN | M_RUN);
    cyc("brn_t5", M_COUT | M_ZLI | M_RUN);
    cyc("brn_t6", M_RUN);
    branchCompare = 1'b0;

    fetch("neg", 32'h8800_0000);
    cyc("neg_t3", M_GRB | M_ROUT | M_ZLI | M_RUN);
    cyc("neg_t4", M_ZLO | M_GRA | M_RIN | M_RUN);

    fetch("mfhi", 32'hC000_0000);
    cyc("mfhi_t3", M_HIO | M_GRA | M_RIN | M_RUN);

    fetch("nop", 32'hD000_0000);

    fetch("mul", 32'h7800_0000);
    cyc("mul_t3", M_GRA | M_ROUT | M_YIN | M_RUN);
    stop = 1'b1;
    cyc("mul_t4", M_GRB | M_ROUT | M_ZHI | M_ZLI | M_RUN);
    cyc("mul_t5", M_ZLO | M_LOI | M_RUN);
    cyc("mul_t6", M_ZHO | M_HII | M_RUN);
    cyc("stop_halt0", 30'h0);
    stop = 1'b0;
    cyc("stop_halt1", 30'h0);

    do_reset();
    fetch("ill", 32'hF000_0000);
    cyc("ill_pulse", M_ILL | M_RUN);
    cyc("ill_halt0", 30'h0);
    cyc("ill_halt1", 30'h0);

    do_reset();
    fetch("halt", 32'hD800_0000);
    for (int i = 0; i < 3; i++) cyc("halt_idle", 30'h0);

    do_reset();
    fetch("abort", 32'h0000_0000);
    cyc("abort_t3", E_AGU3);
    cyc("abort_t4", E_AGU4);
    cyc("abort_t5", M_ZLO | M_MARI | M_RUN);
    check("abort_t6", {2'b00, outs}, {2'b00, M_RD | M_MDRI | M_RUN});
    #2;
    clear = 1'b0;
    #1;
    check("abort_async", {2'b00, outs}, 32'h0);
    @(posedge clock);
    #1;
    check("abort_hold", {2'b00, outs}, 32'h0);
    clear = 1'b1;
    @(posedge clock);
    #1;
    check("abort_t0", {2'b00, outs}, {2'b00, E_T0});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
